// File: rtl/aes_spi_pkg.sv
// aes_spi_pkg: encodings and helpers shared by the AES SPI sequencer.
// Holds FSM states, mode values, key sizes and the header layout.
package aes_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_DONE
    } seq_state_e;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } aes_mode_e;

    localparam int SIZE_128 = 16;
    localparam int SIZE_192 = 24;
    localparam int SIZE_256 = 32;

    localparam int HDR_MODE_BIT = 7;

    function automatic logic key_size_ok(input logic [7:0] ks, input int kmax);
        return ((ks == 8'(SIZE_128)) && (SIZE_128 <= kmax)) ||
               ((ks == 8'(SIZE_192)) && (SIZE_192 <= kmax)) ||
               ((ks == 8'(SIZE_256)) && (SIZE_256 <= kmax));
    endfunction

endpackage

// File: rtl/spi_byte_timer.sv
// spi_byte_timer: one saturating down-counter reused for the inter-byte
// gap and the per-byte timeout; expire flags the final counted cycle.
module spi_byte_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q <= W'(1));

endmodule

// File: rtl/aes_spi_sequencer.sv
// aes_spi_sequencer: streams text, header and key to an SPI byte master,
// then clocks back one result block and presents it in parallel.
module aes_spi_sequencer
    import aes_spi_pkg::*;
#(
    parameter int TEXT_BYTES     = 16,
    parameter int KEY_MAX_BYTES  = 32,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req,
    input  logic                       mode,
    input  logic [7:0]                 key_size,
    input  logic [8*TEXT_BYTES-1:0]    text_in,
    input  logic [8*KEY_MAX_BYTES-1:0] key_in,
    output logic                       busy,
    output logic                       result_valid,
    output logic [8*TEXT_BYTES-1:0]    result,
    output logic                       error,
    output logic                       spi_start,
    output logic [7:0]                 spi_data_in,
    input  logic                       spi_busy,
    input  logic                       spi_done,
    input  logic [7:0]                 spi_data_out
);

    localparam int TW        = 8 * TEXT_BYTES;
    localparam int KW        = 8 * KEY_MAX_BYTES;
    localparam int MAX_XFERS = 2 * TEXT_BYTES + 1 + KEY_MAX_BYTES;
    localparam int CNT_W     = $clog2(MAX_XFERS);
    localparam int TMR_MAX   = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES
                                                             : GAP_CYCLES;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_idx_q, last_idx_d;
    logic [CNT_W-1:0] rx_base_q, rx_base_d;
    logic [7:0]       hdr_q, hdr_d;
    logic [TW-1:0]    text_q, text_d;
    logic [KW-1:0]    key_q, key_d;
    logic [TW-1:0]    rx_q, rx_d;
    logic [TW-1:0]    result_q, result_d;
    logic             error_q, error_d;

    logic             start_c;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_expire;

    logic [TW-1:0]    text_sh;
    logic [KW-1:0]    key_sh;
    logic [CNT_W-1:0] key_idx;
    logic [7:0]       byte_sel;

    spi_byte_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_idx_d = last_idx_q;
        rx_base_d  = rx_base_q;
        hdr_d      = hdr_q;
        text_d     = text_q;
        key_d      = key_q;
        rx_d       = rx_q;
        result_d   = result_q;
        error_d    = 1'b0;
        start_c    = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (key_size_ok(key_size, KEY_MAX_BYTES)) begin
                        state_d    = ST_ISSUE;
                        cnt_d      = '0;
                        text_d     = text_in;
                        key_d      = key_in;
                        hdr_d      = key_size & 8'h7f;
                        hdr_d[HDR_MODE_BIT] = (aes_mode_e'(mode) == MODE_DEC);
                        last_idx_d = CNT_W'(2 * TEXT_BYTES) + CNT_W'(key_size);
                        rx_base_d  = CNT_W'(TEXT_BYTES + 1) + CNT_W'(key_size);
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (!spi_busy) begin
                    start_c  = 1'b1;
                    state_d  = ST_WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(TIMEOUT_CYCLES - 1);
                end
            end
            ST_WAIT: begin
                // a completion in the terminal timeout cycle still counts
                if (spi_done) begin
                    if (cnt_q >= rx_base_q) begin
                        rx_d = (rx_q << 8) | TW'(spi_data_out);
                    end
                    if (cnt_q == last_idx_q) begin
                        state_d  = ST_DONE;
                        result_d = (rx_q << 8) | TW'(spi_data_out);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (GAP_CYCLES == 0) begin
                            state_d = ST_ISSUE;
                        end else begin
                            state_d  = ST_GAP;
                            tmr_load = 1'b1;
                            tmr_val  = TMR_W'(GAP_CYCLES);
                        end
                    end
                end else if (tmr_expire) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (tmr_expire) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        text_sh  = text_q << {cnt_q, 3'b000};
        key_idx  = cnt_q - CNT_W'(TEXT_BYTES + 1);
        key_sh   = key_q << {key_idx, 3'b000};
        byte_sel = 8'h00;
        if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) begin
            unique case (1'b1)
                (cnt_q < CNT_W'(TEXT_BYTES)):
                    byte_sel = text_sh[TW-1 -: 8];
                (cnt_q == CNT_W'(TEXT_BYTES)):
                    byte_sel = hdr_q;
                ((cnt_q > CNT_W'(TEXT_BYTES)) && (cnt_q < rx_base_q)):
                    byte_sel = key_sh[KW-1 -: 8];
                default:
                    byte_sel = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_idx_q <= '0;
            rx_base_q  <= '0;
            hdr_q      <= '0;
            text_q     <= '0;
            key_q      <= '0;
            rx_q       <= '0;
            result_q   <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_idx_q <= last_idx_d;
            rx_base_q  <= rx_base_d;
            hdr_q      <= hdr_d;
            text_q     <= text_d;
            key_q      <= key_d;
            rx_q       <= rx_d;
            result_q   <= result_d;
            error_q    <= error_d;
        end
    end

    assign busy         = (state_q == ST_ISSUE) || (state_q == ST_WAIT) ||
                          (state_q == ST_GAP);
    assign result_valid = (state_q == ST_DONE) && !reset;
    assign result       = result_q;
    assign error        = error_q;
    assign spi_start    = start_c && !reset;
    assign spi_data_in  = byte_sel;

endmodule

// File: tb/tb_aes_spi_sequencer.sv
// tb_aes_spi_sequencer: FIPS-197 known-answer runs through a byte-level
// SPI slave model; a scoreboard checks every result and error pulse.
module tb_aes_spi_sequencer;

    localparam int TB  = 16;
    localparam int KMB = 32;
    localparam int GAP = 2;
    localparam int TMO = 1024;
    localparam int LAT = 3;

    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] JUNK  = 128'hdeadbeefcafef00d0123456789abcdef;
    localparam logic [255:0] K256  =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req = 1'b0;
    logic         mode = 1'b0;
    logic [7:0]   key_size = 8'd0;
    logic [127:0] text_in = '0;
    logic [255:0] key_in = '0;
    logic         busy, result_valid, error, spi_start;
    logic [127:0] result;
    logic [7:0]   spi_data_in;
    logic         spi_busy = 1'b0;
    logic         spi_done = 1'b0;
    logic [7:0]   spi_data_out = 8'h00;

    aes_spi_sequencer #(
        .TEXT_BYTES     (TB),
        .KEY_MAX_BYTES  (KMB),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .mode         (mode),
        .key_size     (key_size),
        .text_in      (text_in),
        .key_in       (key_in),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .error        (error),
        .spi_start    (spi_start),
        .spi_data_in  (spi_data_in),
        .spi_busy     (spi_busy),
        .spi_done     (spi_done),
        .spi_data_out (spi_data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit           is_err;
        logic [127:0] res;
        int           starts;
        logic [7:0]   hdr;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    // Slave answers only the known FIPS-197 vectors; anything else
    // (wrong key, text or header bytes) comes back as the inverted text.
    function automatic logic [127:0] aes_kat(input logic dec, input int ks,
                                             input logic [255:0] k,
                                             input logic [127:0] t);
        if (!dec && ks == 32 && k == K256 && t == PT) return CT256;
        if (!dec && ks == 16 && k == {K128, 128'h0} && t == PT) return CT128;
        if (dec && ks == 32 && k == K256 && t == CT256) return PT;
        if (dec && ks == 16 && k == {K128, 128'h0} && t == CT128) return PT;
        return ~t;
    endfunction

    int           sl_idx = 0;
    int           sl_total = 0;
    int           sl_cnt = 0;
    int           sl_ks = 0;
    int           sl_first_cyc = 0;
    int           sl_done_cyc = 0;
    bit           sl_phase = 1'b0;
    bit           sl_in_txn = 1'b0;
    bit           sl_hang = 1'b0;
    logic [7:0]   sl_byte = 8'h00;
    logic [7:0]   sl_out = 8'h00;
    logic [7:0]   sl_hdr = 8'h00;
    logic [127:0] sl_text = '0;
    logic [127:0] sl_resp = '0;
    logic [255:0] sl_key = '0;

    always @(negedge clk) begin
        spi_done = 1'b0;
        if (!busy) begin
            sl_phase  = 1'b0;
            sl_in_txn = 1'b0;
            spi_busy  = 1'b0;
        end else if (sl_phase) begin
            if (!sl_hang) begin
                if (sl_cnt == 0) begin
                    chk("data_held", spi_data_in, sl_byte);
                    spi_busy     = 1'b0;
                    spi_done     = 1'b1;
                    spi_data_out = sl_out;
                    sl_phase     = 1'b0;
                    sl_done_cyc  = cyc;
                end else begin
                    spi_busy = 1'b1;
                    sl_cnt--;
                end
            end
        end else if (spi_start) begin
            if (sl_in_txn) begin
                chk("gap", cyc, sl_done_cyc + 1 + GAP);
            end else begin
                sl_in_txn    = 1'b1;
                sl_idx       = 0;
                sl_first_cyc = cyc;
                sl_key       = '0;
                sl_text      = '0;
            end
            sl_byte = spi_data_in;
            sl_total++;
            sl_out = 8'h5a ^ 8'(sl_idx);
            if (sl_idx < TB) begin
                sl_text = {sl_text[119:0], sl_byte};
            end else if (sl_idx == TB) begin
                sl_hdr = sl_byte;
                sl_ks  = int'(sl_byte[6:0]);
            end else if (sl_idx < TB + 1 + sl_ks) begin
                sl_key[255 - 8 * (sl_idx - TB - 1) -: 8] = sl_byte;
            end else begin
                chk("rx_fill", sl_byte, 8'h00);
                if (sl_idx == TB + 1 + sl_ks)
                    sl_resp = aes_kat(sl_hdr[7], sl_ks, sl_key, sl_text);
                sl_out = sl_resp[127 - 8 * (sl_idx - TB - 1 - sl_ks) -: 8];
            end
            sl_idx++;
            sl_phase = 1'b1;
            sl_cnt   = LAT;
        end
    end

    always @(negedge clk) begin
        if (!reset && (result_valid || error)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", {result_valid, error}, 2'b00);
            end else begin
                mon_e = sb_q.pop_front();
                chk("out_kind", error, mon_e.is_err);
                chk("result", result, mon_e.res);
                chk("busy_at_out", busy, 1'b0);
                if (!mon_e.is_err) begin
                    chk("n_starts", sl_idx, mon_e.starts);
                    chk("header", sl_hdr, mon_e.hdr);
                end
            end
        end
    end

    task automatic run(input logic m, input logic [7:0] ks,
                       input logic [127:0] t, input logic [255:0] k,
                       input bit exp_err, input logic [127:0] exp_res,
                       input int exp_starts, input logic [7:0] exp_hdr);
        exp_t e;
        int   base;
        int   n;
        e.is_err = exp_err;
        e.res    = exp_res;
        e.starts = exp_starts;
        e.hdr    = exp_hdr;
        sb_q.push_back(e);
        base = sl_total;
        @(negedge clk);
        req = 1'b1; mode = m; key_size = ks; text_in = t; key_in = k;
        @(negedge clk);
        req = 1'b0;
        if (exp_err) begin
            chk("bad_err_pulse", error, 1'b1);
            chk("bad_start", spi_start, 1'b0);
            repeat (4) begin
                chk("bad_busy", busy, 1'b0);
                @(negedge clk);
            end
            chk("bad_no_traffic", sl_total - base, 0);
        end else begin
            chk("first_start", spi_start, 1'b1);
            chk("first_busy", busy, 1'b1);
            chk("first_byte", spi_data_in, t[127:120]);
            mode = ~m; key_size = 8'd24; text_in = ~t; key_in = ~k;
            @(negedge clk);
            req = 1'b1;
            @(negedge clk);
            req = 1'b0;
        end
        n = 0;
        while (sb_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("completion", sb_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   n;
        int   base;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", result_valid, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_start", spi_start, 1'b0);
        chk("rst_data", spi_data_in, 8'h00);
        chk("rst_result", result, 128'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run(1'b0, 8'd32, PT, K256, 1'b0, CT256, 65, 8'h20);
        run(1'b0, 8'd16, PT, {K128, JUNK}, 1'b0, CT128, 49, 8'h10);
        run(1'b1, 8'd32, CT256, K256, 1'b0, PT, 65, 8'ha0);
        run(1'b0, 8'd20, CT128, K256, 1'b1, PT, 0, 8'h00);

        sl_hang = 1'b1;
        e.is_err = 1'b1; e.res = PT; e.starts = 0; e.hdr = 8'h00;
        sb_q.push_back(e);
        @(negedge clk);
        req = 1'b1; mode = 1'b0; key_size = 8'd16;
        text_in = PT; key_in = {K128, JUNK};
        @(negedge clk);
        req = 1'b0;
        chk("tmo_start", spi_start, 1'b1);
        n = 0;
        while (!error && n < TMO + 50) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_latency", cyc - sl_first_cyc, TMO);
        chk("tmo_busy", busy, 1'b0);
        chk("tmo_result", result, PT);
        sl_hang = 1'b0;
        repeat (3) @(negedge clk);

        base = sl_total;
        @(negedge clk);
        req = 1'b1; mode = 1'b0; key_size = 8'd32; text_in = PT; key_in = K256;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while ((sl_total - base) < 30 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach30", sl_total - base, 30);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_start", spi_start, 1'b0);
        chk("mid_rst_data", spi_data_in, 8'h00);
        chk("mid_rst_valid", result_valid, 1'b0);
        chk("mid_rst_error", error, 1'b0);
        chk("mid_rst_result", result, 128'h0);
        repeat (3) @(negedge clk);

        run(1'b0, 8'd16, PT, {K128, JUNK}, 1'b0, CT128, 49, 8'h10);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
